// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a word plus bit count, then shifts the
// selected MSBs out one per accepted cycle with valid/last and a ready stall.
//
// state    | meaning
// ST_IDLE  | waiting for a request with a legal bit count; outputs quiet
// ST_SHIFT | presenting shift-register MSB; advances on ser_ready_i

module serializer #(
   parameter int WIDTH = 16,
   parameter int MOD_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [MOD_W-1:0] data_mod_i,
   input  logic             data_val_i,
   input  logic             ser_ready_i,
   output logic             ser_data_o,
   output logic             ser_data_val_o,
   output logic             ser_last_o,
   output logic             busy_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [MOD_W:0]   r_cnt;
   logic [MOD_W:0]   w_cnt_nxt;
   logic [MOD_W:0]   r_n;
   logic [MOD_W:0]   w_n_nxt;
   logic             w_mod_legal;
   logic             w_last;
   logic             w_active;

   // Counts of 1 and 2 are rejected; 0 encodes a full word.
   assign w_mod_legal = (data_mod_i == '0) || (data_mod_i >= MOD_W'(3));
   assign w_active    = (r_state == ST_SHIFT);
   assign w_last      = (r_cnt == (r_n - (MOD_W+1)'(1)));

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_n     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         r_n     <= w_n_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_n_nxt     = r_n;
      case (r_state)
         ST_IDLE: begin
            if (data_val_i && w_mod_legal) begin
               w_shift_nxt = data_i;
               w_cnt_nxt   = '0;
               w_n_nxt     = (data_mod_i == '0) ? (MOD_W+1)'(WIDTH)
                                                : {1'b0, data_mod_i};
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ser_ready_i) begin
               if (w_last) begin
                  w_shift_nxt = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                  w_cnt_nxt   = r_cnt + (MOD_W+1)'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs decode only flops, so they hold while stalled and clear with reset.
   assign busy_o         = w_active;
   assign ser_data_val_o = w_active;
   assign ser_data_o     = w_active & r_shift[WIDTH-1];
   assign ser_last_o     = w_active & w_last;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed vector table, corner-case
// sequences and randomized words checked against a bit-list reference model.

module tb_serializer;

   localparam int WIDTH = 16;
   localparam int MOD_W = 4;

   logic             clk_i = 1'b0;
   logic             arst_n_i;
   logic [WIDTH-1:0] data_i;
   logic [MOD_W-1:0] data_mod_i;
   logic             data_val_i;
   logic             ser_ready_i;
   logic             ser_data_o;
   logic             ser_data_val_o;
   logic             ser_last_o;
   logic             busy_o;

   int n_cmp  = 0;
   int n_fail = 0;

   serializer #(.WIDTH(WIDTH), .MOD_W(MOD_W)) dut (
      .clk_i          (clk_i),
      .arst_n_i       (arst_n_i),
      .data_i         (data_i),
      .data_mod_i     (data_mod_i),
      .data_val_i     (data_val_i),
      .ser_ready_i    (ser_ready_i),
      .ser_data_o     (ser_data_o),
      .ser_data_val_o (ser_data_val_o),
      .ser_last_o     (ser_last_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [15:0] data;
      logic [3:0]  mod;
      logic [15:0] stall_mask;   // bit k set: bit k is stalled for 2 cycles
      bit          inject;       // pulse a FFFF request mid-word
      logic [15:0] exp_bits;     // expected serial bits, left-aligned
      int          exp_n;
      int          exp_vcyc;
   } vec_t;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_val"},  32'(ser_data_val_o), 32'd0);
      chk({nm, "_busy"}, 32'(busy_o),         32'd0);
      chk({nm, "_last"}, 32'(ser_last_o),     32'd0);
      chk({nm, "_data"}, 32'(ser_data_o),     32'd0);
   endtask

   // Reference: the word's transmitted bits are simply d[15], d[14], ... for n bits.
   task automatic run_word(input string nm, input logic [15:0] d, input logic [3:0] m,
                           input logic [15:0] stall_mask, input bit rand_ready,
                           input bit inject, output int vcyc, output int stalls,
                           output logic [15:0] got);
      int n;
      int k;
      int budget;
      int scnt;
      bit rdy;
      n = (m == 0) ? 16 : int'(m);
      data_i = d; data_mod_i = m; data_val_i = 1'b1; ser_ready_i = 1'b1;
      tick();
      data_val_i = 1'b0;
      data_i = 16'($urandom);
      data_mod_i = 4'($urandom);
      vcyc = 0; stalls = 0; got = '0; k = 0; scnt = 0; budget = 300;
      while (k < n && budget > 0) begin
         budget--;
         if (stall_mask[k] && scnt < 2) begin
            rdy = 1'b0; scnt++;
         end else if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
         else rdy = 1'b1;
         if (!rdy) stalls++;
         ser_ready_i = rdy;
         if (inject && k == n / 2) begin
            data_val_i = 1'b1; data_i = 16'hFFFF; data_mod_i = 4'd0;
         end else data_val_i = 1'b0;
         chk({nm, "_val"},  32'(ser_data_val_o), 32'd1);
         chk({nm, "_busy"}, 32'(busy_o),         32'd1);
         chk({nm, "_bit"},  32'(ser_data_o),     32'(d[15-k]));
         chk({nm, "_last"}, 32'(ser_last_o),     32'(k == n - 1));
         if (ser_data_val_o) vcyc++;
         got[15-k] = ser_data_o;
         tick();
         if (rdy) begin
            k++; scnt = 0;
         end
      end
      if (budget == 0) chk({nm, "_timeout"}, 32'd1, 32'd0);
      data_val_i = 1'b0;
      ser_ready_i = 1'b1;
      chk_idle({nm, "_end"});
   endtask

   vec_t vecs[4];

   initial begin
      int vc;
      int st;
      int n;
      logic [15:0] got;
      logic [15:0] mask;
      logic [15:0] d;
      logic [3:0]  m;

      vecs[0] = '{"full",    16'b1011_0111_1110_0100, 4'd0, 16'h0000, 1'b0,
                  16'b1011_0111_1110_0100, 16, 16};
      vecs[1] = '{"partial", 16'b0010_0001_0110_0111, 4'd5, 16'h0000, 1'b0,
                  16'b0010_0000_0000_0000, 5, 5};
      vecs[2] = '{"stall",   16'b1110_1001_1101_0011, 4'd0, 16'b0000_0000_0011_1000, 1'b0,
                  16'b1110_1001_1101_0011, 16, 22};
      vecs[3] = '{"busydrop", 16'h3C5A, 4'd9, 16'h0000, 1'b1,
                  16'b0011_1100_0000_0000, 9, 9};

      arst_n_i = 1'b0; data_i = '0; data_mod_i = '0; data_val_i = 1'b0; ser_ready_i = 1'b1;
      tick(); tick();
      chk_idle("rst_hold");
      arst_n_i = 1'b1;
      tick();
      chk_idle("rst_rel");

      foreach (vecs[i]) begin
         run_word(vecs[i].name, vecs[i].data, vecs[i].mod, vecs[i].stall_mask, 1'b0,
                  vecs[i].inject, vc, st, got);
         mask = 16'hFFFF << (16 - vecs[i].exp_n);
         chk({vecs[i].name, "_bits"}, 32'(got & mask), 32'(vecs[i].exp_bits));
         chk({vecs[i].name, "_vcyc"}, 32'(vc), 32'(vecs[i].exp_vcyc));
         repeat (3) begin
            tick();
            chk_idle({vecs[i].name, "_noextra"});
         end
      end

      for (int mm = 1; mm <= 2; mm++) begin
         data_i = 16'hFFFF; data_mod_i = 4'(mm); data_val_i = 1'b1;
         tick();
         data_val_i = 1'b0;
         repeat (3) begin
            chk_idle("illegal_mod");
            tick();
         end
      end

      data_i = 16'b1011_0111_1110_0100; data_mod_i = 4'd0; data_val_i = 1'b1; ser_ready_i = 1'b1;
      tick();
      data_val_i = 1'b0;
      repeat (7) tick();
      chk("midrst_pre_val", 32'(ser_data_val_o), 32'd1);
      #2 arst_n_i = 1'b0;
      #1;
      chk_idle("midrst_async");
      tick(); tick();
      arst_n_i = 1'b1;
      repeat (4) begin
         tick();
         chk_idle("midrst_after");
      end
      run_word("a5a5", 16'hA5A5, 4'd0, 16'h0000, 1'b0, 1'b0, vc, st, got);
      chk("a5a5_bits", 32'(got), 32'h0000A5A5);
      chk("a5a5_vcyc", 32'(vc), 32'd16);

      for (int t = 0; t < 40; t++) begin
         d = 16'($urandom);
         m = 4'($urandom_range(0, 15));
         if (m == 4'd1 || m == 4'd2) begin
            data_i = d; data_mod_i = m; data_val_i = 1'b1;
            tick();
            data_val_i = 1'b0;
            chk_idle("rnd_illegal");
            tick();
            chk_idle("rnd_illegal2");
         end else begin
            n = (m == 0) ? 16 : int'(m);
            run_word("rnd", d, m, 16'h0000, 1'b1, t[0], vc, st, got);
            mask = 16'hFFFF << (16 - n);
            chk("rnd_bits", 32'(got & mask), 32'((d >> (16 - n)) << (16 - n)));
            chk("rnd_vcyc", 32'(vc), 32'(n + st));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
